// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory subsystem: arbiter state
// encodings, port identifiers and default bus widths.
package dm_pkg;

  localparam int DM_ADDR_W = 7;
  localparam int DM_DATA_W = 8;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_LOCK_A = 2'd1,
    ARB_LOCK_B = 2'd2
  } arb_state_e;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/dm_rd_pipe.sv
// Two-stage read-return pipeline: tags each read grant with its owner,
// then steers the memory read data into that owner's rdata register.
module dm_rd_pipe
  import dm_pkg::*;
#(
  parameter int DATA_W = DM_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rd_vld,
  input  logic              rd_owner,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata
);

  logic vld_p1;
  logic owner_p1;

  // Stage 1: remember that a read was issued and which port owns it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1   <= 1'b0;
      owner_p1 <= PORT_A;
    end else begin
      vld_p1   <= rd_vld;
      owner_p1 <= rd_owner;
    end
  end

  // Stage 2: capture memory data for the owner and pulse its rvalid
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      a_rvalid <= vld_p1 && (owner_p1 == PORT_A);
      b_rvalid <= vld_p1 && (owner_p1 == PORT_B);
      if (vld_p1 && (owner_p1 == PORT_A)) a_rdata <= mem_rdata;
      if (vld_p1 && (owner_p1 == PORT_B)) b_rdata <= mem_rdata;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Round-robin two-port arbiter in front of the single-port data memory,
// with a per-port lock that holds ownership across multi-access sequences.
module dm_arbiter
  import dm_pkg::*;
#(
  parameter int ADDR_W = DM_ADDR_W,
  parameter int DATA_W = DM_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic              a_lock,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic              b_lock,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_re,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e state;
  logic       rr_ptr;

  // Grant selection: lock owner only, else single requester, else rr_ptr;
  // gated by reset so nothing reaches the memory while reset is held
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (reset_n) begin
      case (state)
        ARB_IDLE: begin
          if (a_req && b_req) begin
            a_gnt = (rr_ptr == PORT_A);
            b_gnt = (rr_ptr == PORT_B);
          end else begin
            a_gnt = a_req;
            b_gnt = b_req;
          end
        end
        ARB_LOCK_A: a_gnt = a_req;
        ARB_LOCK_B: b_gnt = b_req;
        default: begin
          a_gnt = 1'b0;
          b_gnt = 1'b0;
        end
      endcase
    end
  end

  // Memory mux: port A drives addr/wdata unless B holds the grant
  always_comb begin
    mem_addr  = b_gnt ? b_addr : a_addr;
    mem_wdata = b_gnt ? b_wdata : a_wdata;
    mem_we    = (a_gnt && a_we) || (b_gnt && b_we);
    mem_re    = (a_gnt && !a_we) || (b_gnt && !b_we);
  end

  // Arbitration FSM: lock entry/exit and round-robin pointer update
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ARB_IDLE;
      rr_ptr <= PORT_A;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (a_gnt) begin
            rr_ptr <= PORT_B;
            if (a_lock) state <= ARB_LOCK_A;
          end else if (b_gnt) begin
            rr_ptr <= PORT_A;
            if (b_lock) state <= ARB_LOCK_B;
          end
        end
        ARB_LOCK_A: if (a_gnt && !a_lock) state <= ARB_IDLE;
        ARB_LOCK_B: if (b_gnt && !b_lock) state <= ARB_IDLE;
        default:    state <= ARB_IDLE;
      endcase
    end
  end

  dm_rd_pipe #(.DATA_W(DATA_W)) u_rd_pipe (
    .clk       (clk),
    .reset_n   (reset_n),
    .rd_vld    (mem_re),
    .rd_owner  (b_gnt ? PORT_B : PORT_A),
    .mem_rdata (mem_rdata),
    .a_rvalid  (a_rvalid),
    .a_rdata   (a_rdata),
    .b_rvalid  (b_rvalid),
    .b_rdata   (b_rdata)
  );

endmodule

// File: tb/tb_dm_arbiter.sv
// Testbench for dm_arbiter: directed scenarios plus randomized traffic,
// with read returns checked by a scoreboard against a reference model.
module tb_dm_arbiter;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       a_req = 0, a_we = 0, a_lock = 0;
  logic [6:0] a_addr = 0;
  logic [7:0] a_wdata = 0;
  logic       b_req = 0, b_we = 0, b_lock = 0;
  logic [6:0] b_addr = 0;
  logic [7:0] b_wdata = 0;
  logic       a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [7:0] a_rdata, b_rdata;
  logic [6:0] mem_addr;
  logic       mem_we, mem_re;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = 0;

  dm_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Data memory with one-cycle synchronous read
  logic [7:0] mem [128];
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mem[mem_addr];
    if (mem_we) mem[mem_addr] = mem_wdata;
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: who holds the lock (-1 none, 0 A, 1 B), whose turn
  // it is on a tie, and the memory contents as the ports see them
  int         lk_owner = -1;
  int         pref = 0;
  logic [7:0] ref_mem [128];

  typedef struct {
    logic [7:0] data;
    int         due;
  } exp_t;
  exp_t qa[$];
  exp_t qb[$];

  logic       s_agnt, s_bgnt, s_re;
  logic [6:0] s_addr;

  task automatic model_reset();
    lk_owner = -1;
    pref = 0;
    qa.delete();
    qb.delete();
  endtask

  task automatic cycle(input logic ar, input logic aw, input logic al,
                       input logic [6:0] aa, input logic [7:0] ad,
                       input logic br, input logic bw, input logic bl,
                       input logic [6:0] ba, input logic [7:0] bd);
    int         win;
    logic       we, lk;
    logic [6:0] addr;
    logic [7:0] wd;
    exp_t       e;
    a_req = ar; a_we = aw; a_lock = al; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_lock = bl; b_addr = ba; b_wdata = bd;
    @(negedge clk);
    win = -1;
    if (reset_n) begin
      if (lk_owner >= 0) begin
        if ((lk_owner == 0 && ar) || (lk_owner == 1 && br)) win = lk_owner;
      end else if (ar && br) win = pref;
      else if (ar) win = 0;
      else if (br) win = 1;
    end
    s_agnt = a_gnt; s_bgnt = b_gnt; s_re = mem_re; s_addr = mem_addr;
    we   = (win == 1) ? bw : aw;
    lk   = (win == 1) ? bl : al;
    addr = (win == 1) ? ba : aa;
    wd   = (win == 1) ? bd : ad;
    chk("a_gnt", a_gnt, win == 0);
    chk("b_gnt", b_gnt, win == 1);
    chk("mem_we", mem_we, (win >= 0) && we);
    chk("mem_re", mem_re, (win >= 0) && !we);
    chk("mem_addr", mem_addr, addr);
    if (win >= 0 && we) chk("mem_wdata", mem_wdata, wd);
    if (win >= 0) begin
      if (we) ref_mem[addr] = wd;
      else begin
        e.data = ref_mem[addr];
        e.due  = cyc + 2;
        if (win == 0) qa.push_back(e);
        else qb.push_back(e);
      end
      if (lk_owner < 0) begin
        pref = 1 - win;
        if (lk) lk_owner = win;
      end else if (!lk) lk_owner = -1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(0, 0, 0, 7'h0, 8'h0, 0, 0, 0, 7'h0, 8'h0);
  endtask

  // Monitor: every read return must land on its due cycle with model data,
  // and rdata must hold between returns
  logic [7:0] last_a = 0, last_b = 0;
  always @(negedge clk) begin
    logic due;
    exp_t e;
    if (!reset_n) begin
      chk("rst_a_rvalid", a_rvalid, 0);
      chk("rst_b_rvalid", b_rvalid, 0);
      chk("rst_a_rdata", a_rdata, 0);
      chk("rst_b_rdata", b_rdata, 0);
      last_a = 0;
      last_b = 0;
    end else begin
      due = (qa.size() > 0) && (qa[0].due == cyc);
      chk("a_rvalid", a_rvalid, due);
      if (due) begin
        e = qa.pop_front();
        chk("a_rdata", a_rdata, e.data);
        last_a = e.data;
      end else chk("a_rdata_hold", a_rdata, last_a);
      due = (qb.size() > 0) && (qb[0].due == cyc);
      chk("b_rvalid", b_rvalid, due);
      if (due) begin
        e = qb.pop_front();
        chk("b_rdata", b_rdata, e.data);
        last_b = e.data;
      end else chk("b_rdata_hold", b_rdata, last_b);
    end
  end

  initial begin
    logic [7:0] v;
    for (int i = 0; i < 128; i++) begin
      v = 8'($urandom);
      mem[i] = v;
      ref_mem[i] = v;
    end

    // Reset held with both ports requesting: nothing may be granted
    for (int i = 0; i < 3; i++) begin
      cycle(1, 1, 0, 7'h01, 8'hAA, 1, 0, 0, 7'h02, 8'hBB);
      chk("rst_gnt_a", s_agnt, 0);
      chk("rst_gnt_b", s_bgnt, 0);
    end
    reset_n = 1'b1;
    idle();

    // Round-robin alternation starting with A
    for (int i = 0; i < 4; i++) begin
      cycle(1, 1, 0, 7'h01, 8'(8'h10 + i), 1, 1, 0, 7'h02, 8'(8'h20 + i));
      chk("alt_a_gnt", s_agnt, (i % 2) == 0);
      chk("alt_b_gnt", s_bgnt, (i % 2) == 1);
    end
    idle();
    chk("alt_mem1", mem[1], 8'h12);
    chk("alt_mem2", mem[2], 8'h23);

    // Lock held by A across a write and a read while B waits
    cycle(1, 1, 1, 7'h10, 8'h5A, 1, 0, 0, 7'h20, 8'h00);
    chk("lock_wr_a_gnt", s_agnt, 1);
    chk("lock_wr_b_gnt", s_bgnt, 0);
    cycle(1, 0, 0, 7'h10, 8'h00, 1, 0, 0, 7'h20, 8'h00);
    chk("lock_rd_a_gnt", s_agnt, 1);
    chk("lock_rd_b_gnt", s_bgnt, 0);
    cycle(0, 0, 0, 7'h00, 8'h00, 1, 0, 0, 7'h20, 8'h00);
    chk("unlock_b_gnt", s_bgnt, 1);
    idle(); idle();

    // Single read from A with known data
    mem[5] = 8'h3C;
    ref_mem[5] = 8'h3C;
    cycle(1, 0, 0, 7'h05, 8'h00, 0, 0, 0, 7'h00, 8'h00);
    chk("rd5_a_gnt", s_agnt, 1);
    chk("rd5_mem_re", s_re, 1);
    chk("rd5_mem_addr", s_addr, 7'h05);
    idle(); idle();

    // Back-to-back reads routed A, B, A
    cycle(1, 0, 0, 7'h01, 8'h00, 0, 0, 0, 7'h00, 8'h00);
    cycle(0, 0, 0, 7'h00, 8'h00, 1, 0, 0, 7'h02, 8'h00);
    cycle(1, 0, 0, 7'h03, 8'h00, 0, 0, 0, 7'h00, 8'h00);
    idle(); idle(); idle();

    // Reset pulsed while a read is in flight: the return is discarded
    cycle(1, 0, 0, 7'h05, 8'h00, 0, 0, 0, 7'h00, 8'h00);
    reset_n = 1'b0;
    model_reset();
    idle(); idle();
    reset_n = 1'b1;
    idle(); idle(); idle();
    cycle(1, 0, 0, 7'h07, 8'h00, 1, 0, 0, 7'h08, 8'h00);
    chk("post_rst_a_gnt", s_agnt, 1);
    chk("post_rst_b_gnt", s_bgnt, 0);
    idle(); idle();

    // Randomized mixed traffic with occasional locks
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom), 1'($urandom), $urandom_range(3) == 0, 7'($urandom_range(15)), 8'($urandom),
            1'($urandom), 1'($urandom), $urandom_range(3) == 0, 7'($urandom_range(15)), 8'($urandom));
    end
    for (int i = 0; i < 4; i++) idle();
    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-port arbiter that shares the single-port data memory between the SPI slave engine (port A) and a parallel host/debug port (port B). Both ports issue single-beat reads and writes through request/grant handshakes. Fairness is round-robin, and a lock mechanism supports atomic multi-access sequences. The block sits between the SPI front end and the data memory, which has a synchronous read with a 1-cycle latency.

## Interface
- ADDR_W, 7, memory address width
- DATA_W, 8, memory data width
- clk  in  1  system clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- a_req / b_req  in  1  access request, held until granted
- a_we / b_we  in  1  1 = write, 0 = read; valid while req is high
- a_lock / b_lock  in  1  keep ownership after this access; valid while req is high
- a_addr / b_addr  in  ADDR_W  access address
- a_wdata / b_wdata  in  DATA_W  write data
- a_gnt / b_gnt  out  1  access accepted this cycle (combinational)
- a_rvalid / b_rvalid  out  1  read data valid, one-cycle pulse (registered)
- a_rdata / b_rdata  out  DATA_W  read data, registered, held until next read return to that port
- mem_addr  out  ADDR_W  memory address
- mem_we  out  1  memory write enable
- mem_re  out  1  memory read enable
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_re

## Operation
- Arbitration FSM states:
  - IDLE: no owner.
  - LOCK_A: only port A may be granted; b_req is ignored.
  - LOCK_B: mirror of LOCK_A for port B.
- IDLE grant selection:
  - Only one req is high: that port is granted.
  - Both reqs are high: the port named by rr_ptr is granted.
- rr_ptr behaviour:
  - 1 bit.
  - After every grant in IDLE, it points to the port not granted.
  - It is not updated by grants made in a LOCK state.
- Transitions on a grant:
  - Granted with lock=1: IDLE → LOCK_x.
  - In LOCK_x, a grant to x with lock=0 returns the FSM to IDLE.
  - In LOCK_x, a grant to x with lock=1 stays in LOCK_x.
- Grant cycle:
  - mem_addr, mem_we and mem_wdata are muxed from the granted port.
  - mem_re = ~we of the granted port.
  - With no grant: mem_we = mem_re = 0, and mem_addr/mem_wdata keep the port A values.
- Writes complete in the grant cycle; there is no response.
- Read pipeline:
  - Stage 1 registers {valid, owner} on a read grant.
  - Stage 2 captures mem_rdata into the owner's rdata register and pulses that owner's rvalid.
  - Any number of reads may be in flight back-to-back.
- At most one grant per cycle; a_gnt and b_gnt are never both high.
- Reset values:
  - state = IDLE, rr_ptr = A, pipeline valid = 0.
  - a_rvalid = b_rvalid = 0.
  - a_rdata = b_rdata = 0.
  - a_gnt = b_gnt = 0, mem_we = mem_re = 0; these are forced to 0 while reset_n is low, regardless of reqs.

## Timing
- Grant is combinational on the cycle req is seen; the access occurs on that edge.
- Read latency:
  - Grant at cycle T, mem_rdata at T+1, rvalid/rdata at T+2.
  - Fixed, with no stalls.
- Throughput: one access per cycle, mixed reads and writes.
- Simultaneous read grant and read return to the same port: rdata updates and rvalid stays high for consecutive cycles.
- Lock edge cases:
  - The locked owner deasserts req without a final lock=0 access: the lock persists, and the other port starves by design.
  - A write with lock=0 also releases the lock.
- Reset asserted mid-operation:
  - All state, the pipeline and rvalid clear immediately (asynchronous).
  - In-flight read data is discarded; no rvalid is issued after reset releases.
- A req dropped before a grant is legal and is simply not serviced.

## Structure
- Shared package dm_pkg holds:
  - arbiter state encodings: ARB_IDLE=2'd0, ARB_LOCK_A=2'd1, ARB_LOCK_B=2'd2;
  - port IDs: PORT_A=1'b0, PORT_B=1'b1;
  - default ADDR_W/DATA_W constants, shared with the SPI engine and data memory.
- One sub-module, dm_rd_pipe: the 2-stage read-return pipeline (owner tag, rdata and rvalid registers for both ports). Arbitration, the FSM and the mem muxes stay in dm_arbiter.

## Test plan
- Reset, then a_req read addr 0x05 (mem holds 0x3C) → a_gnt pulses at T, mem_re=1 with mem_addr=0x05 at T, a_rvalid=1 and a_rdata=0x3C at T+2, b_rvalid stays 0.
- a_req and b_req both held for 4 cycles with writes to addrs 1/2 → grants alternate A, B, A, B starting with A; memory holds the last-written values.
- a_req lock=1 write 0x10 then lock=0 read 0x10, with b_req high throughout → b_gnt stays 0 for both cycles; B is granted on the cycle after the unlocking access.
- Back-to-back reads A@0x01, B@0x02, A@0x03 on consecutive cycles → rvalids at T+2..T+4 route to A, B, A with the correct data.
- Read granted, then reset_n pulsed low at T+1 → no rvalid is ever issued, state=IDLE, rr_ptr=A; the first request after release is accepted normally.
- reset_n held low with both reqs high → a_gnt, b_gnt, mem_we and mem_re all stay 0.
